// File: rtl/regfile_sb.sv
// regfile_sb: JOF32 decode-stage register file with a pending-write
// scoreboard, two registered read ports with same-edge write bypass,
// a mirrored snapshot of register SNAP_IDX and an any-busy flag.
// Ports: clk, rst (async, active-high); rd_en, addr_a/addr_b ->
// data_a/data_b, busy_a/busy_b; wr_en, wr_addr, wr_data (write-back);
// rsv_en, rsv_addr (reserve at issue); snap, any_busy.
// Optional build macro: REGFILE_ZERO_REG_EN (register 0 hardwired zero).

module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int SNAP_IDX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [DATA_W-1:0] snap,
    output logic              any_busy
);

    localparam int N_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] SNAP_A = ADDR_W'(SNAP_IDX);

    logic [DATA_W-1:0] mem_q [N_REGS];
    logic [DATA_W-1:0] mem_d [N_REGS];
    logic [N_REGS-1:0] sb_q;
    logic [N_REGS-1:0] sb_d;

    logic [DATA_W-1:0] data_a_q, data_a_d;
    logic [DATA_W-1:0] data_b_q, data_b_d;
    logic              busy_a_q, busy_a_d;
    logic              busy_b_q, busy_b_d;
    logic [DATA_W-1:0] snap_q, snap_d;
    logic              any_busy_q, any_busy_d;

    // Post-edge state of storage and scoreboard. Every output is loaded
    // from these, so bypass and same-edge reserve visibility fall out
    // without separate compare logic. Reserve is applied after the
    // write clear so a colliding reserve leaves the bit set.
    always_comb begin
        mem_d = mem_q;
        sb_d  = sb_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
            sb_d[wr_addr]  = 1'b0;
        end
        if (rsv_en) begin
            sb_d[rsv_addr] = 1'b1;
        end
`ifdef REGFILE_ZERO_REG_EN
        mem_d[0] = '0;
        sb_d[0]  = 1'b0;
`endif
    end

    always_comb begin
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        busy_a_d   = busy_a_q;
        busy_b_d   = busy_b_q;
        snap_d     = mem_d[SNAP_A];
        any_busy_d = |sb_d;
        if (rd_en) begin
            data_a_d = mem_d[addr_a];
            data_b_d = mem_d[addr_b];
            busy_a_d = sb_d[addr_a];
            busy_b_d = sb_d[addr_b];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                mem_q[i] <= '0;
            end
            sb_q       <= '0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            busy_a_q   <= 1'b0;
            busy_b_q   <= 1'b0;
            snap_q     <= '0;
            any_busy_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
            sb_q       <= sb_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            busy_a_q   <= busy_a_d;
            busy_b_q   <= busy_b_d;
            snap_q     <= snap_d;
            any_busy_q <= any_busy_d;
        end
    end

    assign data_a   = data_a_q;
    assign data_b   = data_b_q;
    assign busy_a   = busy_a_q;
    assign busy_b   = busy_b_q;
    assign snap     = snap_q;
    assign any_busy = any_busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed bench for regfile_sb.
// Hand-computed expectations; one checking task.

module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic [3:0]  addr_a;
    logic [3:0]  addr_b;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        busy_a;
    logic        busy_b;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic [31:0] snap;
    logic        any_busy;

    int errs;
    int checks;

    regfile_sb #(
        .DATA_W  (32),
        .ADDR_W  (4),
        .SNAP_IDX(15)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (rd_en),
        .addr_a  (addr_a),
        .addr_b  (addr_b),
        .data_a  (data_a),
        .data_b  (data_b),
        .busy_a  (busy_a),
        .busy_b  (busy_b),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rsv_en  (rsv_en),
        .rsv_addr(rsv_addr),
        .snap    (snap),
        .any_busy(any_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en  = 1'b0;
        wr_en  = 1'b0;
        rsv_en = 1'b0;
    endtask

    logic [31:0] z_data;
    logic        z_busy;

    initial begin
        errs    = 0;
        checks  = 0;
        rst     = 1'b1;
        rd_en   = 1'b0;
        addr_a  = '0;
        addr_b  = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rsv_en  = 1'b0;
        rsv_addr = '0;
        step();
        step();
        check("rst_data_a", data_a, 32'h0);
        check("rst_data_b", data_b, 32'h0);
        check("rst_busy", {30'd0, busy_a, busy_b}, 32'h0);
        check("rst_snap", snap, 32'h0);
        check("rst_anyb", {31'd0, any_busy}, 32'h0);
        rst = 1'b0;

        // load r5, reserve r2
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
        rsv_en = 1'b1; rsv_addr = 4'd2;
        step();
        // load r15, read r5/r2
        rsv_en = 1'b0;
        wr_addr = 4'd15; wr_data = 32'h00000077;
        rd_en = 1'b1; addr_a = 4'd5; addr_b = 4'd2;
        step();
        idle();
        check("pre_data_a", data_a, 32'hDEADBEEF);
        check("pre_busy_b", {31'd0, busy_b}, 32'h1);
        check("pre_snap", snap, 32'h77);
        check("pre_anyb", {31'd0, any_busy}, 32'h1);

        // mid-cycle async reset
        #2;
        rst = 1'b1;
        #1;
        check("arst_data_a", data_a, 32'h0);
        check("arst_busy_b", {31'd0, busy_b}, 32'h0);
        check("arst_snap", snap, 32'h0);
        check("arst_anyb", {31'd0, any_busy}, 32'h0);
        step();
        rst = 1'b0;
        rd_en = 1'b1; addr_a = 4'd5; addr_b = 4'd2;
        step();
        idle();
        check("post_rst_r5", data_a, 32'h0);
        check("post_rst_busy2", {31'd0, busy_b}, 32'h0);

        // bypass, both ports same address
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h12345678;
        rd_en = 1'b1; addr_a = 4'd3; addr_b = 4'd3;
        step();
        idle();
        check("byp_a", data_a, 32'h12345678);
        check("byp_b", data_b, 32'h12345678);
        check("byp_busy", {31'd0, busy_a}, 32'h0);

        // scoreboard
        rsv_en = 1'b1; rsv_addr = 4'd7;
        step();
        idle();
        check("sb_anyb_set", {31'd0, any_busy}, 32'h1);
        check("sb_hold_a", data_a, 32'h12345678);
        rd_en = 1'b1; addr_a = 4'd7; addr_b = 4'd3;
        step();
        idle();
        check("sb_busy7", {31'd0, busy_a}, 32'h1);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h55;
        rd_en = 1'b1; addr_a = 4'd7; addr_b = 4'd3;
        step();
        idle();
        check("sb_wr_data", data_a, 32'h55);
        check("sb_wr_busy", {31'd0, busy_a}, 32'h0);
        check("sb_wr_anyb", {31'd0, any_busy}, 32'h0);
        check("sb_r3", data_b, 32'h12345678);

        // collision: reserve wins
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'hA5A5A5A5;
        rsv_en = 1'b1; rsv_addr = 4'd9;
        rd_en = 1'b1; addr_a = 4'd9; addr_b = 4'd3;
        step();
        idle();
        check("col_data", data_a, 32'hA5A5A5A5);
        check("col_busy", {31'd0, busy_a}, 32'h1);
        check("col_anyb", {31'd0, any_busy}, 32'h1);
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h0;
        step();
        idle();
        check("col_clr_anyb", {31'd0, any_busy}, 32'h0);

        // snap with rd_en low
        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h0000002A;
        step();
        idle();
        check("snap_2a", snap, 32'h2A);
        check("snap_hold_a", data_a, 32'hA5A5A5A5);
        check("snap_hold_b", data_b, 32'h12345678);
        rd_en = 1'b1; addr_a = 4'd1; addr_b = 4'd15;
        step();
        idle();
        check("r15_read", data_b, 32'h2A);

        // register 0
`ifdef REGFILE_ZERO_REG_EN
        z_data = 32'h0;
        z_busy = 1'b0;
`else
        z_data = 32'hFFFFFFFF;
        z_busy = 1'b1;
`endif
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFFFFFF;
        rsv_en = 1'b1; rsv_addr = 4'd0;
        step();
        idle();
        rd_en = 1'b1; addr_a = 4'd0; addr_b = 4'd0;
        step();
        idle();
        check("r0_data", data_a, z_data);
        check("r0_busy", {31'd0, busy_a}, {31'd0, z_busy});
        check("r0_anyb", {31'd0, any_busy}, {31'd0, z_busy});

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file for the JOF32 decode stage, with a per-register pending-write scoreboard. It provides two registered read ports and one write-back port, all on a single clock edge, with write-to-read bypass. A continuously mirrored snapshot of one designated register (the pattern-match counter) is exported. Decode uses the scoreboard to reserve destinations at issue and to detect read-after-write hazards.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, register address width; depth is N_REGS = 2**ADDR_W (derived localparam, not overridable)
- SNAP_IDX, 15, index of the register mirrored on snap; must be < N_REGS

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-high
- rd_en  input  1  capture read ports this cycle
- addr_a  input  ADDR_W  read port A address
- addr_b  input  ADDR_W  read port B address
- data_a  output  DATA_W  registered read data A
- data_b  output  DATA_W  registered read data B
- busy_a  output  1  registered scoreboard bit for addr_a
- busy_b  output  1  registered scoreboard bit for addr_b
- wr_en  input  1  write-back enable
- wr_addr  input  ADDR_W  write-back address
- wr_data  input  DATA_W  write-back data
- rsv_en  input  1  reserve a destination register (issue)
- rsv_addr  input  ADDR_W  register to reserve
- snap  output  DATA_W  registered copy of register SNAP_IDX
- any_busy  output  1  registered OR of all scoreboard bits

## Operation
- Storage: N_REGS x DATA_W registers plus an N_REGS-bit scoreboard sb.
- Write: on rising edge with wr_en=1, mem[wr_addr] <= wr_data; sb[wr_addr] cleared.
- Reserve: on rising edge with rsv_en=1, sb[rsv_addr] set.
- Same edge, rsv_addr == wr_addr, both enabled: data written, sb bit ends set (reserve wins; a new producer is pending).
- Read: on rising edge with rd_en=1, data_a/data_b load the register value as it stands after that edge's write (bypass: if wr_en and wr_addr == addr_x, data_x <= wr_data). addr_a == addr_b is legal; both ports return the same value.
- busy_x loads the post-edge sb value for addr_x (includes same-edge write clear and reserve set).
- rd_en=0: data_a, data_b, busy_a, busy_b hold.
- snap loads the post-edge value of mem[SNAP_IDX] every cycle, so snap always equals mem[SNAP_IDX] after each edge.
- any_busy loads the OR of the post-edge sb vector every cycle.
- No read-enable gating on writes, reserves or snap.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by system): all mem entries 0, sb all 0, data_a = data_b = 0, busy_a = busy_b = 0, snap = 0, any_busy = 0. Reset mid-operation discards pending reservations and in-flight writes immediately.
- Read latency: 1 cycle from address presentation to data_x/busy_x.
- Write-to-read: 0 extra cycles (same-edge bypass).
- Reserve-to-busy: visible on busy_x at the same edge the reserve is taken if that register is read that cycle; visible on any_busy after that edge.
- Address wrap: none; every ADDR_W value is a valid register.

## Configuration
- REGFILE_ZERO_REG_EN defined: register 0 is hardwired zero; writes to address 0 ignored (no sb change), reserves to address 0 ignored, reads of address 0 return 0 with busy 0, snap reads 0 if SNAP_IDX = 0.
- Undefined: register 0 is an ordinary register, writable and reservable like all others.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert rst mid-cycle -> all outputs 0 immediately; read r5 after release -> data_a = 0.
- Bypass: same edge wr_en=1, wr_addr=3, wr_data=0x12345678, rd_en=1, addr_a=3, addr_b=3 -> data_a = data_b = 0x12345678 next cycle.
- Scoreboard: rsv r7; next cycle read r7 -> busy_a=1, any_busy=1; write r7=0x55 -> read r7 gives data 0x55, busy 0, any_busy 0.
- Collision: rsv and write r9 on same edge -> mem[9] = wr_data, busy for r9 reads 1, any_busy = 1.
- Snap: write 0x0000002A to r15 -> snap = 0x2A after that edge; rd_en=0 throughout -> data_a/data_b unchanged.
- With REGFILE_ZERO_REG_EN: write 0xFFFFFFFF and rsv to r0 -> read r0 gives 0, busy 0, any_busy 0; without the macro -> 0xFFFFFFFF, busy 1.
